// File: rtl/mem_arbiter.sv
// Purpose : shares one memory port between instruction fetch and data load/store.
// Latency : accept edge T, mem_en in T+1..T+MEM_LATENCY, resp_valid pulse in T+MEM_LATENCY+1.
// Backpressure: ready only in IDLE/RESP, at most one ready; losers hold valid until granted.
//
// Ports: clk/reset (sync, active-high); ireq_*/iresp_* fetch side; dreq_*/dresp_* data side;
//        mem_en/mem_we/mem_addr/mem_wdata/mem_rdata to the external memory.
// MEM_LATENCY: memory cycles per access, legal range 1..15.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration when both requesters
// are valid; without it data always beats fetch and there is no round-robin state.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        ireq_ready,
  output logic        iresp_valid,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [31:0] dreq_wdata,
  input  logic        dreq_we,
  output logic        dreq_ready,
  output logic        dresp_valid,
  output logic [31:0] dresp_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        own_data;   // 1 = current access belongs to the data side
  logic        lat_we;     // current access is a store
  logic        iresp_vld_q;
  logic        dresp_vld_q;
  logic        arb_open;
  logic        pick_data;
  logic        grant_i;
  logic        grant_d;

`ifdef MEM_ARB_RR_EN
  logic        last_data;  // most recent grant went to data; reset value favours data
`endif

  // Arbitration window: IDLE and RESP only, and never while reset is being applied.
  assign arb_open = ((state == IDLE) || (state == RESP)) && !reset;

`ifdef MEM_ARB_RR_EN
  // Contended: take data unless it won last time. Uncontended: whoever asks.
  assign pick_data = dreq_valid && (!ireq_valid || !last_data);
`else
  assign pick_data = dreq_valid;
`endif

  assign grant_d    = arb_open && pick_data;
  assign grant_i    = arb_open && ireq_valid && !pick_data;
  assign dreq_ready = grant_d;
  assign ireq_ready = grant_i;

  // Responses are masked while reset is asserted so an abandoned access never pulses.
  assign iresp_valid = iresp_vld_q && !reset;
  assign dresp_valid = dresp_vld_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      own_data    <= 1'b0;
      lat_we      <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      iresp_vld_q <= 1'b0;
      dresp_vld_q <= 1'b0;
      iresp_data  <= '0;
      dresp_data  <= '0;
`ifdef MEM_ARB_RR_EN
      last_data   <= 1'b0;
`endif
    end else begin
      // Pulses and the write strobe default low; they are raised for one cycle below.
      iresp_vld_q <= 1'b0;
      dresp_vld_q <= 1'b0;
      mem_we      <= 1'b0;

      case (state)
        IDLE, RESP: begin
          if (grant_d || grant_i) begin
            own_data  <= grant_d;
            lat_we    <= grant_d && dreq_we;
            mem_addr  <= grant_d ? dreq_addr : ireq_addr;
            mem_wdata <= grant_d ? dreq_wdata : '0;
            // Strobe only in the first BUSY cycle so a store is written exactly once.
            mem_we    <= grant_d && dreq_we;
            mem_en    <= 1'b1;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
`ifdef MEM_ARB_RR_EN
            last_data <= grant_d;
`endif
          end else begin
            state <= IDLE;
          end
        end

        BUSY: begin
          if (cnt == 4'd0) begin
            // Last memory cycle: mem_rdata is valid now.
            mem_en <= 1'b0;
            state  <= RESP;
            if (own_data) begin
              dresp_vld_q <= 1'b1;
              dresp_data  <= lat_we ? 32'd0 : mem_rdata;
            end else begin
              iresp_vld_q <= 1'b1;
              iresp_data  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between instruction fetch and data load/store. The fetch stage and the memory stage each present a request. The arbiter grants one request at a time and drives the memory port for a fixed latency. It then returns the read data, or a write acknowledge, to the winning requester. It sits between the core's stage logic and the external memory, replacing separate instruction and data buses.

## Interface
- MEM_LATENCY, 2: memory cycles per access, from first mem_en cycle to rdata valid; legal range 1..15.

- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ireq_valid  in  1  fetch request pending
- ireq_addr  in  32  fetch address
- ireq_ready  out  1  fetch request accepted this cycle
- iresp_valid  out  1  one-cycle pulse: iresp_data valid
- iresp_data  out  32  fetched instruction word
- dreq_valid  in  1  data request pending
- dreq_addr  in  32  data address
- dreq_wdata  in  32  store data
- dreq_we  in  1  1 = store, 0 = load
- dreq_ready  out  1  data request accepted this cycle
- dresp_valid  out  1  one-cycle pulse: load data valid, or store done
- dresp_data  out  32  load data; 0 for stores
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid on the last mem_en cycle

## Operation
- States: IDLE, BUSY, RESP.
- Arbitration runs in IDLE and in RESP.
  - The winner's ready is asserted combinationally from the valids. At most one ready is high.
  - On the edge where ready is high, the arbiter latches the winner's addr/wdata/we and owner bit, loads cnt = MEM_LATENCY-1, and moves to BUSY.
- BUSY:
  - mem_en=1; mem_addr and mem_wdata come from the latched registers.
  - mem_we=1 only in the first BUSY cycle of a store; stores write exactly once.
  - cnt decrements each cycle.
  - At cnt==0: capture mem_rdata (or 0 for a store) into the owner's resp_data, set the owner's resp_valid, and go to RESP.
- RESP:
  - Owner's resp_valid=1 for exactly this cycle.
  - If a request is pending, grant it and go to BUSY; otherwise go to IDLE.
- Requesters hold valid and request fields stable until they see ready. Ready is never asserted in BUSY.
- Default priority: data over fetch, because the data access belongs to the older instruction. Fetch may starve; the core stalls fetch anyway.
- resp_data holds its value until the next response to the same requester.

## Timing
- Reset: state=IDLE, cnt=0, all ready/resp_valid/mem_en/mem_we=0, mem_addr/mem_wdata/resp_data=0, rr pointer favours data.
- Accept edge T. BUSY spans cycles T+1..T+MEM_LATENCY. resp_valid is high in cycle T+MEM_LATENCY+1.
- Back-to-back throughput: one access per MEM_LATENCY+1 cycles, because grant overlaps RESP.
- Simultaneous valids: exactly one grant; the loser waits with its valid held.
- Reset while in BUSY or RESP: the transaction is abandoned. No resp_valid pulse, and mem_en=0 in the next cycle. A store in flight may already have been written.
- A valid that deasserts before ready is ignored, with no side effect.

## Configuration
- MEM_ARB_RR_EN defined: when both valids are high at arbitration, grant the requester not granted most recently. A single pending requester is always granted. The rr pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, data wins; there is no rr state.

## Test plan
- Fetch 0x00000040, MEM_LATENCY=2, mem_rdata=0x8C010004 -> ireq_ready at T; mem_en in T+1..T+2 with mem_addr=0x40; iresp_valid only in T+3 with iresp_data=0x8C010004.
- Store 0x100 <- 0xDEADBEEF -> mem_we=1 only in T+1 with mem_wdata=0xDEADBEEF; mem_en in T+1..T+2; dresp_valid in T+3 with dresp_data=0.
- Both valid at T, fixed priority, L=2 -> data granted at T, fetch granted at T+3 (in RESP), iresp_valid at T+6. ireq_ready never high before T+3.
- MEM_ARB_RR_EN defined, both valid continuously for three grants -> grant order data, fetch, data at T, T+3, T+6.
- Load issued, reset asserted at T+1 for one cycle -> dresp_valid stays 0, mem_en=0 from T+2, state IDLE; a new fetch is accepted at T+2.
- MEM_LATENCY=1, back-to-back loads 0x10 then 0x14 -> accepts at T and T+2; dresp_valid at T+2 and T+4 with the correct words.
